// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch stage with IF/ID pipeline register.
// It keeps at most one instruction-memory request in flight, holds PCF and
// applies Execute redirects. StallF/StallD/FlushD from the hazard unit are
// honoured, and a response that arrives while Decode is stalled is parked in
// a one-entry hold buffer.
//
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   StallF, StallD, FlushD            hazard unit controls
//   PCSrcE, PCTargetE                 redirect from Execute
//   imem_req_valid/addr/ready         request channel (addr = PCF)
//   imem_rsp_valid/data               in-order response, 1-cycle pulse
//   PCF                               current fetch PC
//   InstrD, PCD, PCPlus4D, ValidD     IF/ID register contents
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,   // ready to issue a request for PCF
        S_WAIT  = 2'd1,   // request accepted, waiting for its response
        S_HOLD  = 2'd2,   // response parked in hold buffer while Decode stalls
        S_DRAIN = 2'd3    // outstanding response is stale and must be dropped
    } stateT;

    stateT            state, stateNext;
    logic [XLEN-1:0]  pcfNext;
    logic [XLEN-1:0]  holdInstr, holdInstrNext;
    logic [XLEN-1:0]  instrDNext, pcDNext, pcPlus4DNext;
    logic             validDNext;
    logic             deliver;
    logic [XLEN-1:0]  deliverInstr;
    logic [XLEN-1:0]  pcfPlus4;
    logic             accept;
    logic             kill;

    // Request channel: only from REQ, never during reset, stall or redirect.
    assign imem_req_valid = (state == S_REQ) & ~StallF & ~PCSrcE & ~reset;
    assign imem_req_addr  = PCF;
    assign accept         = imem_req_valid & imem_req_ready;
    assign pcfPlus4       = PCF + XLEN'(4);
    // Either a redirect or a Decode flush invalidates the in-flight fetch.
    assign kill           = PCSrcE | FlushD;

    // State register and IF/ID register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_REQ;
            PCF       <= RESET_PC;
            holdInstr <= '0;
            InstrD    <= NOP_INSTR;
            PCD       <= '0;
            PCPlus4D  <= '0;
            ValidD    <= 1'b0;
        end else begin
            state     <= stateNext;
            PCF       <= pcfNext;
            holdInstr <= holdInstrNext;
            InstrD    <= instrDNext;
            PCD       <= pcDNext;
            PCPlus4D  <= pcPlus4DNext;
            ValidD    <= validDNext;
        end
    end

    // Next-state, PC and IF/ID update logic.
    always_comb begin
        stateNext     = state;
        pcfNext       = PCF;
        holdInstrNext = holdInstr;
        deliver       = 1'b0;
        deliverInstr  = holdInstr;
        instrDNext    = NOP_INSTR;
        pcDNext       = '0;
        pcPlus4DNext  = '0;
        validDNext    = 1'b0;

        unique case (state)
            S_REQ: begin
                // Responses seen here belong to requests killed by reset.
                if (accept) begin
                    stateNext = S_WAIT;
                end
            end
            S_WAIT: begin
                if (kill) begin
                    // Same-cycle response lets us skip DRAIN entirely.
                    stateNext = imem_rsp_valid ? S_REQ : S_DRAIN;
                end else if (imem_rsp_valid) begin
                    if (!StallD) begin
                        deliver      = 1'b1;
                        deliverInstr = imem_rsp_data;
                        stateNext    = S_REQ;
                    end else begin
                        holdInstrNext = imem_rsp_data;
                        stateNext     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (kill) begin
                    stateNext = S_REQ;
                end else if (!StallD) begin
                    deliver   = 1'b1;
                    stateNext = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_rsp_valid) begin
                    stateNext = S_REQ;
                end
            end
            default: begin
                stateNext = S_REQ;
            end
        endcase

        // PC advances only on delivery; a redirect always wins.
        if (deliver) begin
            pcfNext = pcfPlus4;
        end
        if (PCSrcE) begin
            pcfNext = PCTargetE;
        end

        // IF/ID priority: flush, then stall, then delivery, else bubble.
        if (FlushD) begin
            instrDNext   = NOP_INSTR;
            pcDNext      = '0;
            pcPlus4DNext = '0;
            validDNext   = 1'b0;
        end else if (StallD) begin
            instrDNext   = InstrD;
            pcDNext      = PCD;
            pcPlus4DNext = PCPlus4D;
            validDNext   = ValidD;
        end else if (deliver) begin
            instrDNext   = deliverInstr;
            pcDNext      = PCF;
            pcPlus4DNext = pcfPlus4;
            validDNext   = 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: randomized and directed stimulus, a memory model
// with variable latency, and a transaction-level reference model whose
// predictions are checked by a separate monitor through queues.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D;
    logic        ValidD;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .reset(reset),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ValidD(ValidD)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic v; logic [31:0] pc; } reqExpT;
    typedef struct packed { logic [31:0] pc; logic [31:0] instr; logic [31:0] pc4; } delExpT;

    reqExpT reqQ[$];
    delExpT expQ[$];

    int nChecks = 0;
    int nFail   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] memData(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Reference model: program counter plus "fetch in flight / killed / parked".
    logic [31:0] mPc;
    logic        mOut, mKill, mBuf;
    logic [31:0] mBufD;

    // Memory model.
    logic        memBusy = 1'b0;
    int          memCnt = 0;
    logic [31:0] memAddr = '0;
    int          fixLat = 1;   // 0 selects random latency 1..3

    // Per-cycle stimulus knobs.
    logic        sF, sD, fD, br, rdy;
    logic [31:0] tgt;

    task automatic modelReset();
        mPc = RESET_PC; mOut = 1'b0; mKill = 1'b0; mBuf = 1'b0; mBufD = '0;
        expQ.delete();
    endtask

    task automatic modelDeliver(logic [31:0] d);
        expQ.push_back('{pc: mPc, instr: d, pc4: mPc + 32'd4});
        mPc = mPc + 32'd4;
    endtask

    // One clock cycle: entered just after a rising edge, leaves just after the next.
    task automatic step();
        logic        rspV, expReq, acc;
        logic [31:0] rspD, accAddr;
        StallF = sF; StallD = sD; FlushD = fD; PCSrcE = br; PCTargetE = tgt;
        imem_req_ready = rdy;
        rspV = memBusy && (memCnt == 0);
        rspD = rspV ? memData(memAddr) : $urandom;
        imem_rsp_valid = rspV;
        imem_rsp_data  = rspD;

        expReq = !reset && !mOut && !mBuf && !sF && !br;
        reqQ.push_back('{v: expReq, pc: mPc});

        if (!reset) begin
            if (mOut && rspV) begin
                mOut = 1'b0;
                if (!mKill && !br && !fD) begin
                    if (sD) begin mBuf = 1'b1; mBufD = rspD; end
                    else modelDeliver(rspD);
                end
                mKill = 1'b0;
            end else if (mOut && (br || fD)) begin
                mKill = 1'b1;
            end else if (mBuf) begin
                if (br || fD) mBuf = 1'b0;
                else if (!sD) begin modelDeliver(mBufD); mBuf = 1'b0; end
            end
            if (expReq && rdy) begin mOut = 1'b1; mKill = 1'b0; end
            if (br) mPc = tgt;
        end

        #1;
        acc     = imem_req_valid && rdy;
        accAddr = imem_req_addr;
        @(posedge clk);
        #1;
        if (rspV) memBusy = 1'b0;
        else if (memBusy) memCnt--;
        if (acc) begin
            memBusy = 1'b1;
            memAddr = accAddr;
            memCnt  = (fixLat == 0) ? $urandom_range(2, 0) : fixLat - 1;
        end
    endtask

    task automatic idle(int n, logic stallFetch);
        for (int i = 0; i < n; i++) begin
            sF = stallFetch; sD = 1'b0; fD = 1'b0; br = 1'b0; tgt = '0; rdy = 1'b1;
            step();
        end
    endtask

    // Monitor: request channel and PCF every cycle, IF/ID on each delivery.
    initial begin
        reqExpT r;
        delExpT e;
        logic   sDe, fDe, rstE;
        forever begin
            @(posedge clk);
            sDe = StallD; fDe = FlushD; rstE = reset;
            @(negedge clk);
            if (reqQ.size() > 0) begin
                r = reqQ.pop_front();
                chk("req_valid", 32'(imem_req_valid), 32'(r.v));
                chk("PCF", PCF, r.pc);
                if (r.v) chk("req_addr", imem_req_addr, r.pc);
            end
            if (!ValidD) begin
                chk("bubble", InstrD ^ PCD ^ PCPlus4D, NOP_INSTR);
            end else if (!rstE && !sDe && !fDe) begin
                if (expQ.size() == 0) begin
                    chk("unexpected_delivery_pc", PCD, 32'hDEAD_BEEF);
                end else begin
                    e = expQ.pop_front();
                    chk("PCD", PCD, e.pc);
                    chk("InstrD", InstrD, e.instr);
                    chk("PCPlus4D", PCPlus4D, e.pc4);
                end
            end
        end
    end

    initial begin
        modelReset();
        sF = 1'b0; sD = 1'b0; fD = 1'b0; br = 1'b0; tgt = '0; rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_PCF", PCF, RESET_PC);
        chk("rst_InstrD", InstrD, NOP_INSTR);
        chk("rst_PCD", PCD, 32'h0);
        chk("rst_PCPlus4D", PCPlus4D, 32'h0);
        chk("rst_ValidD", 32'(ValidD), 32'h0);
        StallF = 1'b0; imem_req_ready = 1'b1;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        reset = 1'b0;
        modelReset();

        // Straight-line fetch with 1-cycle latency.
        fixLat = 1;
        idle(10, 1'b0);

        // Decode stall over a response, then release.
        sF = 1'b0; fD = 1'b0; br = 1'b0; rdy = 1'b1;
        sD = 1'b0; step();
        sD = 1'b1; repeat (3) step();
        idle(4, 1'b0);

        // Redirect while waiting, and redirect coinciding with a response.
        fixLat = 2;
        idle(1, 1'b0);
        sD = 1'b0; fD = 1'b0; br = 1'b1; tgt = 32'h0000_0100; step();
        idle(5, 1'b0);
        fixLat = 1;
        idle(1, 1'b0);
        br = 1'b1; tgt = 32'h0000_0200; step();
        idle(4, 1'b0);

        // Flush while waiting: same PC must be refetched.
        fixLat = 2;
        idle(1, 1'b0);
        br = 1'b0; fD = 1'b1; step();
        idle(5, 1'b0);

        // Memory not ready with StallF toggling.
        fixLat = 1;
        idle(4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            sF = i[0]; sD = 1'b0; fD = 1'b0; br = 1'b0; rdy = 1'b0; step();
        end
        idle(4, 1'b0);

        // PC wrap at the top of the address space.
        idle(3, 1'b1);
        sF = 1'b0; br = 1'b1; tgt = 32'hFFFF_FFFC; rdy = 1'b1; step();
        idle(6, 1'b0);

        // Reset in WAIT with the response arriving after release.
        fixLat = 3;
        idle(4, 1'b1);
        idle(1, 1'b0);
        reset = 1'b1; modelReset();
        idle(2, 1'b1);
        reset = 1'b0; modelReset();
        idle(2, 1'b1);
        fixLat = 1;
        idle(6, 1'b0);

        // Randomized traffic.
        fixLat = 0;
        for (int i = 0; i < 3000; i++) begin
            sF  = ($urandom % 5) == 0;
            sD  = ($urandom % 4) == 0;
            fD  = ($urandom % 10) == 0;
            br  = ($urandom % 12) == 0;
            rdy = ($urandom % 4) != 0;
            tgt = (($urandom % 8) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
            step();
        end

        // Let everything in flight retire, then nothing may remain expected.
        idle(3, 1'b0);
        idle(8, 1'b1);
        @(negedge clk);
        #1;
        chk("pending_deliveries", 32'(expQ.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        nFail++;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $fatal(1, "timeout");
    end

endmodule
